// File: rtl/booth_datapath_if.sv
// Control link between the Booth controller and its datapath: control codes
// flow toward the datapath, the Q register and Q-1 bit flow back.
interface booth_datapath_if #(
   parameter int WIDTH = 4
);
   logic             mSignal;
   logic             addSubSignal;
   logic [1:0]       aSignal;
   logic [1:0]       qSignal;
   logic             finished;
   logic [WIDTH-1:0] qReg;
   logic             qNeg;

   modport master (
      output mSignal, addSubSignal, aSignal, qSignal, finished,
      input  qReg, qNeg
   );

   modport slave (
      input  mSignal, addSubSignal, aSignal, qSignal, finished,
      output qReg, qNeg
   );
endinterface

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: A/M/Q/Q-1 registers driven by controller codes,
// with edge-triggered capture of the final {A,Q} product.
module booth_datapath #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   booth_datapath_if.slave      ctrl,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 productValid
);

   typedef enum logic [1:0] {
      A_HOLD  = 2'b00,
      A_CLEAR = 2'b01,
      A_LOAD  = 2'b10,
      A_ASR   = 2'b11
   } a_op_e;

   typedef enum logic [1:0] {
      Q_HOLD  = 2'b00,
      Q_LOAD  = 2'b01,
      Q_SHIFT = 2'b10,
      Q_CLEAR = 2'b11
   } q_op_e;

   // A and M carry one guard bit so -2^(W-1) * -2^(W-1) is exact.
   logic [WIDTH:0]   a_r;
   logic [WIDTH:0]   m_r;
   logic [WIDTH:0]   alu;
   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next;
   logic             q_neg_r;
   logic             q_neg_next;
   logic             fin_d;
   logic             capture;

   always_comb begin
      alu = ctrl.addSubSignal ? (a_r - m_r) : (a_r + m_r);
   end

   // A and Q decode independently from pre-edge values; together ASR + shift
   // forms the combined sign-filled shift of {A,Q,Q-1}.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      a_next     = a_r;
      q_next     = q_r;
      q_neg_next = q_neg_r;

      case (a_op_e'(ctrl.aSignal))
         A_CLEAR: a_next = '0;
         A_LOAD:  a_next = alu;
         A_ASR:   a_next = {a_r[WIDTH], a_r[WIDTH:1]};
         default: ;
      endcase

      case (q_op_e'(ctrl.qSignal))
         Q_LOAD: begin
            q_next     = multiplier;
            q_neg_next = 1'b0;
         end
         Q_SHIFT: begin
            q_next     = {a_r[0], q_r[WIDTH-1:1]};
            q_neg_next = q_r[0];
         end
         Q_CLEAR: begin
            q_next     = '0;
            q_neg_next = 1'b0;
         end
         default: ;
      endcase
   end

   assign capture = ctrl.finished & ~fin_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r          <= '0;
         m_r          <= '0;
         q_r          <= '0;
         q_neg_r      <= 1'b0;
         fin_d        <= 1'b0;
         product      <= '0;
         productValid <= 1'b0;
      end else begin
         a_r          <= a_next;
         q_r          <= q_next;
         q_neg_r      <= q_neg_next;
         fin_d        <= ctrl.finished;
         productValid <= capture;
         if (ctrl.mSignal)
            m_r <= {multiplicand[WIDTH-1], multiplicand};
         if (capture)
            product <= {a_r[WIDTH-1:0], q_r};
      end
   end

   assign ctrl.qReg = q_r;
   assign ctrl.qNeg = q_neg_r;

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: directed Booth runs, register-level
// corner cases and randomized control traffic against a behavioural model.
module tb_booth_datapath;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic [2*W-1:0] product;
   logic           productValid;

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   booth_datapath_if #(.WIDTH(W)) bus ();

   booth_datapath #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .ctrl         (bus),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .productValid (productValid)
   );

   always #5 clk = ~clk;

   // Behavioural model: whole-register arithmetic on the architectural state.
   typedef struct packed {
      logic [W:0]     a;
      logic [W:0]     m;
      logic [W-1:0]   q;
      logic           qn;
      logic           fin;
      logic [2*W-1:0] prod;
      logic           valid;
   } model_t;

   model_t md;

   function automatic model_t model_step(input model_t s, input logic rst, input logic ms,
                                         input logic sub, input logic [1:0] aop,
                                         input logic [1:0] qop, input logic fin,
                                         input logic [W-1:0] mc, input logic [W-1:0] mp);
      model_t n;
      n = s;
      if (rst) begin
         n = '0;
      end else begin
         n.valid = fin && !s.fin;
         if (n.valid)
            n.prod = {s.a[W-1:0], s.q};
         n.fin = fin;
         if (aop == 2'b11 && qop == 2'b10) begin
            {n.a, n.q, n.qn} = $signed({s.a, s.q, s.qn}) >>> 1;
         end else begin
            case (aop)
               2'b01: n.a = '0;
               2'b10: n.a = sub ? s.a - s.m : s.a + s.m;
               2'b11: n.a = $signed(s.a) >>> 1;
               default: ;
            endcase
            case (qop)
               2'b01: begin n.q = mp; n.qn = 1'b0; end
               2'b10: begin n.q = {s.a[0], s.q[W-1:1]}; n.qn = s.q[0]; end
               2'b11: begin n.q = '0; n.qn = 1'b0; end
               default: ;
            endcase
         end
         if (ms)
            n.m = {mc[W-1], mc};
      end
      return n;
   endfunction

   always @(posedge clk)
      md <= model_step(md, reset, bus.mSignal, bus.addSubSignal, bus.aSignal, bus.qSignal,
                       bus.finished, multiplicand, multiplier);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: outputs are stable mid-cycle, checked every falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("m_qReg",         64'(bus.qReg),       64'(md.q));
         check("m_qNeg",         64'(bus.qNeg),       64'(md.qn));
         check("m_product",      64'(product),        64'(md.prod));
         check("m_productValid", 64'(productValid),   64'(md.valid));
         check("m_a",            64'(dut.a_r),        64'(md.a));
      end
   end

   task automatic cyc(input logic rst, input logic ms, input logic sub,
                      input logic [1:0] aop, input logic [1:0] qop, input logic fin,
                      input logic [W-1:0] mc, input logic [W-1:0] mp);
      @(negedge clk);
      reset            = rst;
      bus.mSignal      = ms;
      bus.addSubSignal = sub;
      bus.aSignal      = aop;
      bus.qSignal      = qop;
      bus.finished     = fin;
      multiplicand     = mc;
      multiplier       = mp;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic fin);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, fin, '0, '0);
   endtask

   task automatic load_ops(input logic [W-1:0] mc, input logic [W-1:0] mp);
      cyc(1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, mc, mp);
   endtask

   // Acts as the controller: W Booth steps, then a finished rise and fall.
   task automatic run_iter(output logic [2*W-1:0] prod, output logic pulse);
      logic [1:0] pair;
      for (int i = 0; i < W; i++) begin
         pair = {bus.qReg[0], bus.qNeg};
         if (pair == 2'b01)
            cyc(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, '0, '0);
         else if (pair == 2'b10)
            cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, '0, '0);
         cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, '0, '0);
      end
      idle(1'b1);
      prod  = product;
      pulse = productValid;
      idle(1'b0);
   endtask

   task automatic run_booth(input logic [W-1:0] mc, input logic [W-1:0] mp,
                            input logic [2*W-1:0] exp, input string name);
      logic [2*W-1:0] prod;
      logic           pulse;
      load_ops(mc, mp);
      run_iter(prod, pulse);
      check({name, "_product"}, 64'(prod), 64'(exp));
      check({name, "_valid"}, 64'(pulse), 64'd1);
   endtask

   initial begin
      logic [2*W-1:0] prod;
      logic           pulse;
      logic signed [2*W-1:0] exp_s;
      logic [W-1:0] mc;
      logic [W-1:0] mp;
      int pulses;

      cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, '0, '0);
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, '0, '0);
      check_en = 1'b1;
      check("rst_qReg",         64'(bus.qReg),     64'd0);
      check("rst_qNeg",         64'(bus.qNeg),     64'd0);
      check("rst_product",      64'(product),      64'd0);
      check("rst_productValid", 64'(productValid), 64'd0);

      // 3 x -5
      load_ops(4'b0011, 4'b1011);
      check("load_qReg", 64'(bus.qReg), 64'(4'b1011));
      check("load_qNeg", 64'(bus.qNeg), 64'd0);
      run_iter(prod, pulse);
      check("p3xm5_product", 64'(prod), 64'h00F1);
      check("p3xm5_valid",   64'(pulse), 64'd1);
      check("p3xm5_pulse_len", 64'(productValid), 64'd0);

      run_booth(4'b1000, 4'b1000, 8'h40, "m8xm8");
      run_booth(4'b0111, 4'b1000, 8'hC8, "p7xm8");

      // Combined shift from A=1_0110, Q=1001, Q-1=0
      cyc(1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 4'b1011, 4'b1001);
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, '0, '0);
      check("shift_setup_a", 64'(dut.a_r), 64'(5'b10110));
      cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, '0, '0);
      check("shift_a",    64'(dut.a_r),   64'(5'b11011));
      check("shift_qReg", 64'(bus.qReg),  64'(4'b0100));
      check("shift_qNeg", 64'(bus.qNeg),  64'd1);

      // Q shift alone with A=0_0001, Q=0000
      cyc(1'b0, 1'b1, 1'b0, 2'b01, 2'b11, 1'b0, 4'b0001, '0);
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, '0, '0);
      check("qshift_qReg", 64'(bus.qReg), 64'(4'b1000));
      check("qshift_a",    64'(dut.a_r),  64'(5'b00001));

      // Add/sub wrap with M=0111, A=1_1001
      cyc(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4'b1001, '0);
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, '0, '0);
      check("wrap_setup_a", 64'(dut.a_r), 64'(5'b11001));
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0111, '0);
      cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, '0, '0);
      check("wrap_sub_a", 64'(dut.a_r), 64'(5'b10010));
      cyc(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4'b1001, '0);
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, '0, '0);
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0111, '0);
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, '0, '0);
      check("wrap_add_a", 64'(dut.a_r), 64'(5'b00000));

      // finished held high for 3 cycles, then dropped and re-raised; {A,Q}=0000_1000
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         pulses += int'(productValid);
      end
      check("fin_hold_pulses", 64'(pulses), 64'd1);
      idle(1'b0);
      check("fin_low_valid", 64'(productValid), 64'd0);
      idle(1'b1);
      check("fin_rerise_valid",   64'(productValid), 64'd1);
      check("fin_rerise_product", 64'(product),      64'h0008);
      idle(1'b0);

      // Reset mid-multiply while loading A and raising finished
      load_ops(4'b0101, 4'b0011);
      cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, '0, '0);
      cyc(1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, '0, '0);
      check("midrst_qReg",    64'(bus.qReg),     64'd0);
      check("midrst_qNeg",    64'(bus.qNeg),     64'd0);
      check("midrst_product", 64'(product),      64'd0);
      check("midrst_valid",   64'(productValid), 64'd0);
      check("midrst_a",       64'(dut.a_r),      64'd0);
      check("midrst_m",       64'(dut.m_r),      64'd0);
      idle(1'b0);
      check("postrst_valid", 64'(productValid), 64'd0);
      run_booth(4'b0010, 4'b0011, 8'h06, "p2xp3");

      // Random control traffic, model-checked every cycle
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
             2'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      end
      idle(1'b0);

      // Random full multiplies checked against plain signed arithmetic
      for (int i = 0; i < 60; i++) begin
         mc = 4'($urandom);
         mp = 4'($urandom);
         exp_s = $signed(mc) * $signed(mp);
         run_booth(mc, mp, exp_s, "rand_mul");
      end

      idle(1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
